// File: rtl/button_step_pkg.sv
// Shared types and timing constants for the button step conditioner.
// Defaults target a 100 MHz clock; the SIM_* set keeps simulations short.
package button_step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } step_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 2500000;   // 25 ms
    localparam int DEF_HOLD_CYCLES     = 50000000;  // 0.5 s
    localparam int DEF_REPEAT_CYCLES   = 25000000;  // 0.25 s
    localparam int DEF_CNT_W           = 28;

    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_HOLD_CYCLES     = 10;
    localparam int SIM_REPEAT_CYCLES   = 5;
    localparam int SIM_CNT_W           = 8;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stable-sample debouncer for one button.
// rise is a one-cycle flag aligned with the cycle the level first reads 1.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;

    // Any cycle where sync agrees with level restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
                rise_d  = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            meta_q  <= raw;
            sync_q  <= meta_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/button_step_conditioner.sv
// Converts two bouncy push-buttons into single-cycle inc/dec step pulses with
// hold-to-repeat and mutual lockout while both buttons are held.
module button_step_conditioner
    import button_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_dn_raw,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic up_level,
    output logic dn_level
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0] raw_w;
    logic [1:0] level_w;
    logic [1:0] rise_w;
    logic [1:0] pulse_w;

    assign raw_w = {btn_dn_raw, btn_up_raw};

    for (genvar i = 0; i < 2; i++) begin : g_step
        step_state_e      state_q;
        logic [CNT_W-1:0] timer_q;
        logic             pulse_q;
        logic             own_level;
        logic             other_level;

        debounce_sync #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_w[i]),
            .level(level_w[i]),
            .rise (rise_w[i])
        );

        assign own_level   = level_w[i];
        assign other_level = level_w[1-i];

        // The FSM keeps advancing under lockout; only the pulse is masked.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                unique case (state_q)
                    ST_IDLE: begin
                        timer_q <= '0;
                        if (rise_w[i]) begin
                            pulse_q <= ~other_level;
                            state_q <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (!own_level) begin
                            timer_q <= '0;
                            state_q <= ST_IDLE;
                        end else if (timer_q == HOLD_LAST) begin
                            pulse_q <= ~other_level;
                            timer_q <= '0;
                            state_q <= ST_REPEAT;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!own_level) begin
                            timer_q <= '0;
                            state_q <= ST_IDLE;
                        end else if (timer_q == REPEAT_LAST) begin
                            pulse_q <= ~other_level;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    default: begin
                        timer_q <= '0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end

        assign pulse_w[i] = pulse_q;
    end

    assign inc_pulse = pulse_w[0];
    assign dec_pulse = pulse_w[1];
    assign up_level  = level_w[0];
    assign dn_level  = level_w[1];

endmodule

// File: tb/tb_button_step_conditioner.sv
// Bench for button_step_conditioner with short timing (debounce 4, hold 10, repeat 5).
// Expected pulse cycles are queued when buttons are driven and matched as pulses appear.
module tb_button_step_conditioner;

    localparam int DEB = 4;
    localparam int HLD = 10;
    localparam int RPT = 5;

    logic clk;
    logic rst;
    logic btn_up_raw;
    logic btn_dn_raw;
    logic inc_pulse;
    logic dec_pulse;
    logic up_level;
    logic dn_level;

    int checks;
    int failures;
    int cyc;

    logic [31:0] exp_inc_q[$];
    logic [31:0] exp_dec_q[$];

    button_step_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HLD),
        .REPEAT_CYCLES  (RPT),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up_raw(btn_up_raw),
        .btn_dn_raw(btn_dn_raw),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse),
        .up_level  (up_level),
        .dn_level  (dn_level)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: count the rising edge, then score pulses at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
        checks = checks + 1;
        if (inc_pulse && dec_pulse) begin
            failures = failures + 1;
            $display("FAIL both_pulses: cycle %0d inc=%0b dec=%0b, required not both 1", cyc, inc_pulse, dec_pulse);
        end
        if (exp_inc_q.size() > 0 && exp_inc_q[0] < cyc) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL inc_missed: cycle %0d no inc_pulse, required one at cycle %0d", cyc, exp_inc_q[0]);
            void'(exp_inc_q.pop_front());
        end
        if (inc_pulse) begin
            checks = checks + 1;
            if (exp_inc_q.size() > 0 && exp_inc_q[0] == cyc) begin
                void'(exp_inc_q.pop_front());
            end else begin
                failures = failures + 1;
                $display("FAIL inc_unexpected: inc_pulse=1 at cycle %0d, required 0", cyc);
            end
        end
        if (exp_dec_q.size() > 0 && exp_dec_q[0] < cyc) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL dec_missed: cycle %0d no dec_pulse, required one at cycle %0d", cyc, exp_dec_q[0]);
            void'(exp_dec_q.pop_front());
        end
        if (dec_pulse) begin
            checks = checks + 1;
            if (exp_dec_q.size() > 0 && exp_dec_q[0] == cyc) begin
                void'(exp_dec_q.pop_front());
            end else begin
                failures = failures + 1;
                $display("FAIL dec_unexpected: dec_pulse=1 at cycle %0d, required 0", cyc);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_up_raw = 1'b1;
        btn_dn_raw = 1'b1;
        idle(3);
        checks = checks + 1;
        if ({inc_pulse, dec_pulse, up_level, dn_level} !== 4'b0000) begin
            failures = failures + 1;
            $display("FAIL reset_outputs: got inc/dec/up/dn=%b, required 0000", {inc_pulse, dec_pulse, up_level, dn_level});
        end
        btn_up_raw = 1'b0;
        btn_dn_raw = 1'b0;
        rst = 1'b0;
        idle(12);
        checks = checks + 1;
        if ({up_level, dn_level} !== 2'b00) begin
            failures = failures + 1;
            $display("FAIL reset_levels: got up/dn=%b, required 00", {up_level, dn_level});
        end
    endtask

    task automatic test_clean_press();
        int n;
        n = cyc;
        btn_up_raw = 1'b1;
        exp_inc_q.push_back(n + DEB + 3);
        for (int k = 1; k <= DEB + 3; k++) begin
            tick();
            if (k == DEB + 1) begin
                checks = checks + 1;
                if (up_level !== 1'b0) begin
                    failures = failures + 1;
                    $display("FAIL clean_level_early: up_level=%b at +%0d, required 0", up_level, k);
                end
            end
            if (k == DEB + 2) begin
                checks = checks + 1;
                if (up_level !== 1'b1) begin
                    failures = failures + 1;
                    $display("FAIL clean_level_rise: up_level=%b at +%0d, required 1", up_level, k);
                end
            end
        end
        btn_up_raw = 1'b0;
        idle(20);
        checks = checks + 1;
        if (exp_inc_q.size() != 0 || exp_dec_q.size() != 0 || up_level !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL clean_end: pending inc=%0d dec=%0d up_level=%b, required 0 0 0", exp_inc_q.size(), exp_dec_q.size(), up_level);
        end
    endtask

    task automatic test_bounce();
        int n;
        n = cyc;
        for (int k = 0; k < 10; k++) begin
            btn_up_raw = ((k % 2) == 0);
            tick();
            tick();
            checks = checks + 1;
            if (up_level !== 1'b0) begin
                failures = failures + 1;
                $display("FAIL bounce_level: up_level=%b during bounce at +%0d, required 0", up_level, cyc - n);
            end
        end
        btn_up_raw = 1'b1;
        exp_inc_q.push_back(cyc + DEB + 3);
        idle(DEB + 3);
        btn_up_raw = 1'b0;
        idle(20);
        checks = checks + 1;
        if (exp_inc_q.size() != 0 || up_level !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL bounce_end: pending inc=%0d up_level=%b, required 0 0", exp_inc_q.size(), up_level);
        end
    endtask

    task automatic test_down_hold();
        int n;
        int a;
        n = cyc;
        a = n + DEB + 2;
        btn_dn_raw = 1'b1;
        exp_dec_q.push_back(a + 1);
        for (int p = 0; p < 6; p++) exp_dec_q.push_back(a + 1 + HLD + p * RPT);
        while (cyc < a + 34) tick();
        btn_dn_raw = 1'b0;
        while (cyc < a + 39) tick();
        checks = checks + 1;
        if (dn_level !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL hold_level_held: dn_level=%b at +39, required 1", dn_level);
        end
        tick();
        checks = checks + 1;
        if (dn_level !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL hold_level_release: dn_level=%b at +40, required 0", dn_level);
        end
        idle(20);
        checks = checks + 1;
        if (exp_dec_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL hold_count: %0d dec pulses outstanding, required 0", exp_dec_q.size());
        end
    endtask

    task automatic test_lockout();
        int n;
        n = cyc;
        btn_up_raw = 1'b1;
        exp_inc_q.push_back(n + 7);
        exp_inc_q.push_back(n + 27);
        exp_inc_q.push_back(n + 32);
        exp_inc_q.push_back(n + 37);
        idle(2);
        btn_dn_raw = 1'b1;
        while (cyc < n + 8) tick();
        checks = checks + 1;
        if ({up_level, dn_level} !== 2'b11) begin
            failures = failures + 1;
            $display("FAIL lockout_levels: up/dn=%b, required 11", {up_level, dn_level});
        end
        while (cyc < n + 20) tick();
        btn_dn_raw = 1'b0;
        while (cyc < n + 33) tick();
        btn_up_raw = 1'b0;
        idle(25);
        checks = checks + 1;
        if (exp_inc_q.size() != 0 || exp_dec_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL lockout_end: pending inc=%0d dec=%0d, required 0 0", exp_inc_q.size(), exp_dec_q.size());
        end
    endtask

    task automatic test_reset_mid_repeat();
        int n;
        n = cyc;
        btn_up_raw = 1'b1;
        exp_inc_q.push_back(n + 7);
        exp_inc_q.push_back(n + 17);
        while (cyc < n + 20) tick();
        rst = 1'b1;
        tick();
        checks = checks + 1;
        if ({inc_pulse, dec_pulse, up_level, dn_level} !== 4'b0000) begin
            failures = failures + 1;
            $display("FAIL midrst_outputs: inc/dec/up/dn=%b, required 0000", {inc_pulse, dec_pulse, up_level, dn_level});
        end
        rst = 1'b0;
        exp_inc_q.push_back(cyc + DEB + 3);
        tick();
        checks = checks + 1;
        if (inc_pulse !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL midrst_no_pulse: inc_pulse=%b after reset, required 0", inc_pulse);
        end
        while (cyc < n + 29) tick();
        btn_up_raw = 1'b0;
        idle(20);
        checks = checks + 1;
        if (exp_inc_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL midrst_end: %0d inc pulses outstanding, required 0", exp_inc_q.size());
        end
    endtask

    task automatic test_short_press();
        btn_up_raw = 1'b1;
        idle(DEB - 1);
        btn_up_raw = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks = checks + 1;
            if (up_level !== 1'b0) begin
                failures = failures + 1;
                $display("FAIL short_level: up_level=%b at +%0d, required 0", up_level, k);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst = 1'b1;
        btn_up_raw = 1'b0;
        btn_dn_raw = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_down_hold();
        test_lockout();
        test_reset_mid_repeat();
        test_short_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
